floppy_track_loader: RTL and testbench

- Per-drive Apple II floppy track cache sitting between the disk controller (apple2_top) and the SD block-device handshake.
- Holds one whole track: 13 sectors × 512 B = 6656 B.
- On a track change or image mount it writes back a dirty track if needed, then reads the new track's 13 sectors from SD.
- Stalls the CPU during transfers; one instance per drive.

---
 rtl/floppy_pkg.sv | 21 ++
 rtl/track_dpram.sv | 37 +++
 rtl/floppy_track_loader.sv | 187 ++++++++++++++++++
 tb/tb_floppy_track_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floppy_pkg.sv
// Shared constants, state encoding and LBA helper for the floppy track cache.
package floppy_pkg;

  localparam int SECTORS_PER_TRACK = 13;
  localparam int SECTOR_BYTES      = 512;
  localparam int TRACK_BYTES       = SECTORS_PER_TRACK * SECTOR_BYTES;  // 6656
  localparam int BUF_AW            = 14;                                // controller byte address width

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    START_READ,
    READ
  } state_t;

  // First SD sector of a track: 13 * track, zero-extended to 32 bits.
  function automatic logic [31:0] track_lba(input logic [5:0] trk);
    return {26'd0, trk} * 32'(SECTORS_PER_TRACK);
  endfunction

endpackage

// File: rtl/track_dpram.sv
// True dual-port RAM, both ports on one clock, registered (1-cycle) read data.
// A read and a write to the same word in one cycle return the old contents.
// Ports:
//   clk              clock
//   addr_a/we_a/din_a/dout_a   port A (address, write enable, write data, read data)
//   addr_b/we_b/din_b/dout_b   port B (same)
module track_dpram #(
  parameter int AW     = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr_a,
  input  logic              we_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic [AW-1:0]     addr_b,
  input  logic              we_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];
  logic [DATA_W-1:0] q_a_p1;
  logic [DATA_W-1:0] q_b_p1;

  // stage p0 -> p1: array access, read data registered
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    q_a_p1 <= mem[addr_a];
    q_b_p1 <= mem[addr_b];
  end

  assign dout_a = q_a_p1;
  assign dout_b = q_b_p1;

endmodule

// File: rtl/floppy_track_loader.sv
// Per-drive Apple II floppy track cache between the disk controller and the
// SD block-device handshake. Holds one whole track (13 x 512 B); on a track
// change or image mount it optionally writes the dirty track back, then reads
// the new track from SD, stalling the CPU for the whole sequence.
//
// Build option: define DIRTY_WRITEBACK_EN to write dirty tracks back to SD.
// Without it sd_wr is tied low and controller writes live only in the cache.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   active                       drive selected by the controller
//   track                        requested track (0-63)
//   img_mounted, img_size        mount pulse and image size (0 = no image)
//   lba_fdd, sd_rd, sd_wr        SD sector address and read/write requests
//   sd_ack                       SD busy with one 512 B sector
//   sd_buff_addr/wr/dout/din     SD byte stream in/out of the cache
//   cpu_wait_fdd                 CPU stall request
//   fd_track_addr, fd_write_disk, fd_data_do, fd_data_in   controller byte port
import floppy_pkg::*;

module floppy_track_loader #(
  parameter int DRIVE_NUM = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        active,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  output logic [31:0] lba_fdd,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  output logic        cpu_wait_fdd,
  input  logic [13:0] fd_track_addr,
  input  logic        fd_write_disk,
  input  logic [7:0]  fd_data_do,
  output logic [7:0]  fd_data_in
);

  localparam int RAM_AW = BUF_AW - 1;  // 8 KiB window covers the 6656 B track

  // The drive index only labels the instance; a negative value is meaningless.
  if (DRIVE_NUM < 0) begin : g_invalid_drive_num
  end

  state_t      state;
  logic [5:0]  cur_track;
  logic [3:0]  track_sec;
  logic        mounted;
  logic        reload;
  logic        old_ack;
  logic        ack_rise;
  logic        ack_fall;

  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;

`ifdef DIRTY_WRITEBACK_EN
  logic dirty;
  logic sd_wr_r;
  assign sd_wr = sd_wr_r;
`else
  assign sd_wr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      mounted      <= 1'b0;
      reload       <= 1'b0;
      cur_track    <= 6'h3F;
      track_sec    <= 4'd0;
      lba_fdd      <= 32'd0;
      sd_rd        <= 1'b0;
      cpu_wait_fdd <= 1'b0;
      old_ack      <= 1'b0;
`ifdef DIRTY_WRITEBACK_EN
      dirty        <= 1'b0;
      sd_wr_r      <= 1'b0;
`endif
    end else begin
      old_ack <= sd_ack;
`ifdef DIRTY_WRITEBACK_EN
      if (fd_write_disk && active) dirty <= 1'b1;
`endif

      case (state)
        IDLE: begin
          if (mounted && ((cur_track != track) || reload)) begin
`ifdef DIRTY_WRITEBACK_EN
            if (dirty) begin
              track_sec    <= 4'd0;
              lba_fdd      <= track_lba(cur_track);
              sd_wr_r      <= 1'b1;
              cpu_wait_fdd <= 1'b1;
              dirty        <= 1'b0;
              state        <= WRITE;
            end else begin
              state <= START_READ;
            end
`else
            state <= START_READ;
`endif
          end
        end

`ifdef DIRTY_WRITEBACK_EN
        WRITE: begin
          // Request drops on the rise of the last sector's ack; the state
          // moves on once that sector's ack has fallen.
          if (ack_rise) begin
            lba_fdd <= lba_fdd + 32'd1;
            if (track_sec >= 4'd12) sd_wr_r <= 1'b0;
          end
          if (ack_fall) begin
            track_sec <= track_sec + 4'd1;
            if (!sd_wr_r) state <= START_READ;
          end
        end
`endif

        START_READ: begin
          cur_track    <= track;
          reload       <= 1'b0;
          track_sec    <= 4'd0;
          lba_fdd      <= track_lba(track);
          sd_rd        <= 1'b1;
          cpu_wait_fdd <= 1'b1;
          state        <= READ;
        end

        READ: begin
          if (ack_rise) begin
            lba_fdd <= lba_fdd + 32'd1;
            if (track_sec >= 4'd12) sd_rd <= 1'b0;
          end
          if (ack_fall) begin
            track_sec <= track_sec + 4'd1;
            if (!sd_rd) begin
              cpu_wait_fdd <= 1'b0;
              state        <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Mount bookkeeping is last so a mount always wins over a reload
      // being cleared in START_READ and over dirty being set this cycle.
      if (img_mounted) begin
        if (img_size != 64'd0) begin
          mounted <= 1'b1;
          reload  <= 1'b1;
`ifdef DIRTY_WRITEBACK_EN
          dirty   <= 1'b0;
`endif
        end else begin
          mounted <= 1'b0;
        end
      end
    end
  end

  // Port A: SD side, sector selected by track_sec. Port B: controller side;
  // bytes above the 8 KiB window lie outside any track and are not written.
  track_dpram #(
    .AW     (RAM_AW),
    .DATA_W (8)
  ) u_ram (
    .clk    (clk),
    .addr_a ({track_sec, sd_buff_addr}),
    .we_a   (sd_ack & sd_buff_wr),
    .din_a  (sd_buff_dout),
    .dout_a (sd_buff_din),
    .addr_b (fd_track_addr[RAM_AW-1:0]),
    .we_b   (fd_write_disk & active & ~fd_track_addr[RAM_AW]),
    .din_b  (fd_data_do),
    .dout_b (fd_data_in)
  );

endmodule

// File: tb/tb_floppy_track_loader.sv
module tb_floppy_track_loader;
  import floppy_pkg::*;

`ifdef DIRTY_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        active = 1'b0;
  logic [5:0]  track = 6'd0;
  logic        img_mounted = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic [31:0] lba_fdd;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = 9'd0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_dout = 8'd0;
  logic [7:0]  sd_buff_din;
  logic        cpu_wait_fdd;
  logic [13:0] fd_track_addr = 14'd0;
  logic        fd_write_disk = 1'b0;
  logic [7:0]  fd_data_do = 8'd0;
  logic [7:0]  fd_data_in;

  floppy_track_loader #(.DRIVE_NUM(0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .active        (active),
    .track         (track),
    .img_mounted   (img_mounted),
    .img_size      (img_size),
    .lba_fdd       (lba_fdd),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_wr    (sd_buff_wr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_din   (sd_buff_din),
    .cpu_wait_fdd  (cpu_wait_fdd),
    .fd_track_addr (fd_track_addr),
    .fd_write_disk (fd_write_disk),
    .fd_data_do    (fd_data_do),
    .fd_data_in    (fd_data_in)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: SD image, expected cache contents, dirty/track state.
  logic [7:0] disk_w [int];
  logic [7:0] model_cache [0:16383];
  bit         cache_ok [0:16383];
  bit         model_dirty = 1'b0;
  int         model_trk = 63;
  int         serve_sec = 0;
  bit         exp_ok = 1'b0;
  logic [7:0] exp_q = 8'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [7:0] disk_byte(input int lba, input int a);
    if (disk_w.exists(lba * 512 + a)) return disk_w[lba * 512 + a];
    return 8'((lba * 37) + (a * 11) + (a >> 3) + 8'h5A);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int idx;
    if (exp_ok) chk("fd_data_in", fd_data_in, exp_q);
    chk("rd_wr_exclusive", sd_rd & sd_wr, 1'b0);
`ifndef DIRTY_WRITEBACK_EN
    chk("sd_wr_tied_low", sd_wr, 1'b0);
`endif
    exp_ok = cache_ok[fd_track_addr];
    exp_q  = model_cache[fd_track_addr];
    if (fd_write_disk && active) begin
      model_cache[fd_track_addr] = fd_data_do;
      cache_ok[fd_track_addr]    = 1'b1;
    end
    if (sd_ack && sd_buff_wr) begin
      idx = serve_sec * 512 + int'(sd_buff_addr);
      model_cache[idx] = sd_buff_dout;
      cache_ok[idx]    = 1'b1;
    end
  end

  task automatic wait_req(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (sd_rd || sd_wr) break;
      tick();
    end
    chk(nm, sd_rd | sd_wr, 1'b1);
  endtask

  // One SD sector transfer, acting as the SD block device.
  task automatic serve_sector(input int lba, input int sec, input bit is_rd);
    chk("sector_lba", lba_fdd, 64'(lba));
    chk("sector_wait_hi", cpu_wait_fdd, 1'b1);
    serve_sec = sec;
    sd_ack = 1'b1;
    for (int a = 0; a < 512; a++) begin
      sd_buff_addr = 9'(a);
      sd_buff_wr   = is_rd;
      sd_buff_dout = is_rd ? disk_byte(lba, a) : 8'd0;
      tick();
      if (a == 0) begin
        if (is_rd) chk("sd_rd_level", sd_rd, (sec < 12));
        else       chk("sd_wr_level", sd_wr, (sec < 12));
      end
      if (!is_rd && a > 0) begin
        chk("wb_data", sd_buff_din, model_cache[sec * 512 + a - 1]);
        disk_w[lba * 512 + a - 1] = sd_buff_din;
      end
    end
    sd_buff_wr = 1'b0;
    tick();
    if (!is_rd) begin
      chk("wb_data", sd_buff_din, model_cache[sec * 512 + 511]);
      disk_w[lba * 512 + 511] = sd_buff_din;
    end
    sd_ack = 1'b0;
    repeat (1 + $urandom_range(0, 3)) tick();
  endtask

  task automatic do_load(input int new_trk, input bit expect_wb);
    int old_trk = model_trk;
    wait_req("req_start");
    if (expect_wb) begin
      chk("wb_sd_wr", sd_wr, 1'b1);
      chk("wb_sd_rd", sd_rd, 1'b0);
      for (int i = 0; i < 13; i++) serve_sector(13 * old_trk + i, i, 1'b0);
      for (int i = 0; i < 50; i++) begin
        if (sd_rd) break;
        chk("wait_between", cpu_wait_fdd, 1'b1);
        tick();
      end
    end
    chk("rd_sd_rd", sd_rd, 1'b1);
    chk("rd_sd_wr", sd_wr, 1'b0);
    for (int i = 0; i < 13; i++) serve_sector(13 * new_trk + i, i, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (!cpu_wait_fdd) break;
      tick();
    end
    chk("wait_release", cpu_wait_fdd, 1'b0);
    chk("lba_end", lba_fdd, 64'(13 * new_trk + 13));
    chk("rd_done", sd_rd, 1'b0);
    model_trk   = new_trk;
    model_dirty = 1'b0;
  endtask

  task automatic random_writes(input int n);
    for (int i = 0; i < n; i++) begin
      fd_track_addr = 14'($urandom_range(0, TRACK_BYTES - 1));
      fd_write_disk = ($urandom_range(0, 3) == 0);
      active        = $urandom_range(0, 1);
      fd_data_do    = 8'($urandom);
      if (fd_write_disk && active) model_dirty = 1'b1;
      tick();
    end
    fd_write_disk = 1'b0;
    tick();
  endtask

  initial begin
    int nt;

    // Reset state
    repeat (3) tick();
    chk("rst_lba", lba_fdd, 32'd0);
    chk("rst_sd_rd", sd_rd, 1'b0);
    chk("rst_sd_wr", sd_wr, 1'b0);
    chk("rst_wait", cpu_wait_fdd, 1'b0);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("no_mount_idle", sd_rd | sd_wr | cpu_wait_fdd, 1'b0);

    // Mount with track 0
    disk_w[2 * 512 + 7] = 8'hA5;
    img_size    = 64'd143360;
    track       = 6'd0;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    wait_req("mount_req");
    chk("mount_sd_rd", sd_rd, 1'b1);
    chk("mount_lba", lba_fdd, 32'd0);
    chk("mount_wait", cpu_wait_fdd, 1'b1);
    do_load(0, 1'b0);
    chk("track0_lba13", lba_fdd, 32'd13);

    fd_track_addr = 14'h0407;
    tick();
    chk("byte_0407", fd_data_in, 8'hA5);

    for (int i = 0; i < 200; i++) begin
      fd_track_addr = 14'($urandom_range(0, TRACK_BYTES - 1));
      active        = $urandom_range(0, 1);
      tick();
    end

    // Write while inactive: no cache change, no dirty
    active        = 1'b0;
    fd_track_addr = 14'h0020;
    fd_data_do    = 8'h77;
    fd_write_disk = 1'b1;
    tick();
    fd_write_disk = 1'b0;
    tick();
    chk("inactive_wr", fd_data_in, disk_byte(0, 32));

    // Clean track change -> read only
    track = 6'd17;
    wait_req("t17_req");
    chk("t17_lba", lba_fdd, 32'd221);
    chk("t17_no_wr", sd_wr, 1'b0);
    do_load(17, WB_EN && model_dirty);

    // Dirty track change
    active        = 1'b1;
    fd_track_addr = 14'h0010;
    fd_data_do    = 8'h3C;
    fd_write_disk = 1'b1;
    model_dirty   = 1'b1;
    tick();
    fd_write_disk = 1'b0;
    tick();
    track = 6'd18;
    wait_req("t18_req");
`ifdef DIRTY_WRITEBACK_EN
    chk("t18_wb_lba", lba_fdd, 32'd221);
    chk("t18_wb_wr", sd_wr, 1'b1);
`else
    chk("t18_rd_lba", lba_fdd, 32'd234);
`endif
    do_load(18, WB_EN && model_dirty);
`ifdef DIRTY_WRITEBACK_EN
    chk("wb_byte16", disk_byte(221, 16), 8'h3C);
`endif
    chk("t18_end_lba", lba_fdd, 32'd247);

    // Random writes then random track change
    random_writes(40);
    nt = 20 + $urandom_range(0, 40);
    track = 6'(nt);
    do_load(nt, WB_EN && model_dirty);

    // Remount on same track: reload forced, dirty discarded
    random_writes(20);
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    model_dirty = 1'b0;
    do_load(model_trk, 1'b0);

    // Back to track 17
    track = 6'd17;
    do_load(17, WB_EN && model_dirty);
    fd_track_addr = 14'h0010;
    tick();
`ifdef DIRTY_WRITEBACK_EN
    chk("roundtrip_3c", fd_data_in, 8'h3C);
`else
    chk("lost_write", fd_data_in, disk_byte(221, 16));
`endif

    // Reset in the middle of a read
    track = 6'd40;
    wait_req("t40_req");
    serve_sector(520, 0, 1'b1);
    serve_sector(521, 1, 1'b1);
    serve_sec = 2;
    sd_ack = 1'b1;
    for (int a = 0; a < 100; a++) begin
      sd_buff_addr = 9'(a);
      sd_buff_wr   = 1'b1;
      sd_buff_dout = disk_byte(522, a);
      tick();
    end
    reset_n = 1'b0;
    tick();
    chk("abort_sd_rd", sd_rd, 1'b0);
    chk("abort_wait", cpu_wait_fdd, 1'b0);
    chk("abort_lba", lba_fdd, 32'd0);
    chk("abort_sd_wr", sd_wr, 1'b0);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("post_reset_quiet", sd_rd | sd_wr | cpu_wait_fdd, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
